// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM encoding, width defaults and timeout read-data for mem_arbiter
package mem_arb_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam logic [15:0] TIMEOUT_RDATA = 16'hFFFF;
endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick: two-way grant selection, fixed priority (mode=0) or round-robin (mode=1)
module arb_pick (
    input  logic m0_req,
    input  logic m1_req,
    input  logic last_grant,
    input  logic mode,
    output logic grant_valid,
    output logic grant_id
);
    assign grant_valid = m0_req | m1_req;
    assign grant_id = (m0_req & m1_req) ? (mode & ~last_grant) : m1_req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master memory port arbiter; define ARB_TIMEOUT_EN to abort stalled BUSY with error
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RR_EN_MODE = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_w,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_w,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_valid,
    output logic              mem_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              error
);
    logic [1:0] state;
    logic last_grant, grant_valid, grant_id, expire, fin;
    logic [DATA_W-1:0] fin_data;

    arb_pick u_pick (
        .m0_req(m0_req),
        .m1_req(m1_req),
        .last_grant(last_grant),
        .mode(RR_EN_MODE != 0),
        .grant_valid(grant_valid),
        .grant_id(grant_id)
    );

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt;
    assign expire = state == BUSY && !mem_ready && cnt == 8'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            error <= 1'b0;
        end else begin
            cnt <= state == BUSY ? cnt + {7'd0, !mem_ready} : 8'd0;
            error <= error | expire;
        end
    end
`else
    assign expire = 1'b0;
    assign error = TIMEOUT < 0;
`endif

    assign fin = state == BUSY && (mem_ready || expire);
    assign fin_data = mem_ready ? mem_rdata : DATA_W'(TIMEOUT_RDATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mem_valid <= 1'b0;
            mem_w <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            owner <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            case (state)
                IDLE: if (grant_valid) begin
                    state <= BUSY;
                    mem_valid <= 1'b1;
                    owner <= grant_id;
                    last_grant <= grant_id;
                    mem_w <= grant_id ? m1_w : m0_w;
                    mem_addr <= grant_id ? m1_addr : m0_addr;
                    mem_wdata <= grant_id ? m1_wdata : m0_wdata;
                end
                BUSY: if (fin) begin
                    state <= DONE;
                    mem_valid <= 1'b0;
                    m0_ready <= !owner;
                    m1_ready <= owner;
                    if (expire || !mem_w) begin
                        m0_rdata <= owner ? m0_rdata : fin_data;
                        m1_rdata <= owner ? fin_data : m1_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter in round-robin and fixed-priority builds
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic m0_req, m0_w, m1_req, m1_w, mem_ready;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;
    logic r_m0_ready, r_m1_ready, r_mem_valid, r_mem_w, r_owner, r_error;
    logic [15:0] r_m0_rdata, r_m1_rdata, r_mem_addr, r_mem_wdata;
    logic f_m0_ready, f_m1_ready, f_mem_valid, f_mem_w, f_owner, f_error;
    logic [15:0] f_m0_rdata, f_m1_rdata, f_mem_addr, f_mem_wdata;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RR_EN_MODE(1), .TIMEOUT(4)) u_rr (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_w(m0_w), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(r_m0_ready), .m0_rdata(r_m0_rdata),
        .m1_req(m1_req), .m1_w(m1_w), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(r_m1_ready), .m1_rdata(r_m1_rdata),
        .mem_valid(r_mem_valid), .mem_w(r_mem_w), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .owner(r_owner), .error(r_error)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RR_EN_MODE(0), .TIMEOUT(4)) u_fp (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_w(m0_w), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(f_m0_ready), .m0_rdata(f_m0_rdata),
        .m1_req(m1_req), .m1_w(m1_w), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(f_m1_ready), .m1_rdata(f_m1_rdata),
        .mem_valid(f_mem_valid), .mem_w(f_mem_w), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .owner(f_owner), .error(f_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {m0_req, m0_w, m1_req, m1_w, mem_ready} = '0;
        {m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata} = '0;
        step();
        step();
        chk("rst_mem_valid", r_mem_valid, 0);
        chk("rst_mem_bus", {r_mem_w, r_mem_addr, r_mem_wdata}, 0);
        chk("rst_ready", {r_m0_ready, r_m1_ready, f_m0_ready, f_m1_ready}, 0);
        chk("rst_rdata", {r_m0_rdata, r_m1_rdata}, 0);
        chk("rst_owner_err", {r_owner, r_error, f_owner, f_error}, 0);
        rst = 1'b0;
        step();

        // single read by m0, ready in second BUSY cycle
        m0_req = 1'b1;
        m0_addr = 16'h0020;
        step();
        chk("rd_valid", r_mem_valid, 1);
        chk("rd_addr", r_mem_addr, 16'h0020);
        chk("rd_w", r_mem_w, 0);
        chk("rd_owner", r_owner, 0);
        step();
        chk("rd_wait_ready", r_m0_ready, 0);
        mem_ready = 1'b1;
        mem_rdata = 16'h1234;
        step();
        chk("rd_m0_ready", r_m0_ready, 1);
        chk("rd_m0_rdata", r_m0_rdata, 16'h1234);
        chk("rd_m1_ready", r_m1_ready, 0);
        chk("rd_done_valid", r_mem_valid, 0);
        m0_req = 1'b0;
        mem_ready = 1'b0;
        step();
        chk("rd_ready_pulse", r_m0_ready, 0);

        // both masters held: RR alternates, fixed priority always m0
        reset_dut();
        m0_req = 1'b1;
        m1_req = 1'b1;
        m0_addr = 16'h0100;
        m1_addr = 16'h0200;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("rr_owner", r_owner, i % 2);
            chk("rr_addr", r_mem_addr, (i % 2) ? 16'h0200 : 16'h0100);
            chk("fp_owner", f_owner, 0);
            mem_ready = 1'b1;
            mem_rdata = 16'hA000 + 16'(i);
            step();
            chk("rr_ready", {r_m0_ready, r_m1_ready}, (i % 2) ? 2'b01 : 2'b10);
            chk("fp_ready", {f_m0_ready, f_m1_ready}, 2'b10);
            mem_ready = 1'b0;
            if (i == 3) {m0_req, m1_req} = 2'b00;
            step();
            step();
        end
        chk("rr_m0_rdata", r_m0_rdata, 16'hA002);
        chk("rr_m1_rdata", r_m1_rdata, 16'hA003);
        chk("fp_rdata", {f_m0_rdata, f_m1_rdata}, {16'hA003, 16'h0000});
        chk("rr_idle", r_mem_valid, 0);

        // m1 write; request fields change while BUSY
        m1_req = 1'b1;
        m1_w = 1'b1;
        m1_addr = 16'hFFFE;
        m1_wdata = 16'hBEEF;
        step();
        chk("wr_bus", {r_mem_valid, r_mem_w, r_mem_addr, r_mem_wdata}, {2'b11, 16'hFFFE, 16'hBEEF});
        chk("wr_owner", r_owner, 1);
        m1_addr = 16'h0000;
        m1_w = 1'b0;
        m1_wdata = 16'h0000;
        step();
        chk("wr_bus_stable", {r_mem_valid, r_mem_w, r_mem_addr, r_mem_wdata}, {2'b11, 16'hFFFE, 16'hBEEF});
        mem_ready = 1'b1;
        mem_rdata = 16'h5555;
        step();
        chk("wr_ready", {r_m0_ready, r_m1_ready}, 2'b01);
        chk("wr_rdata_kept", r_m1_rdata, 16'hA003);
        m1_req = 1'b0;
        mem_ready = 1'b0;
        step();

        // reset in second BUSY cycle abandons the transaction
        m0_req = 1'b1;
        m0_addr = 16'h0040;
        step();
        step();
        chk("ab_busy", r_mem_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ab_valid", r_mem_valid, 0);
        chk("ab_ready", {r_m0_ready, r_m1_ready}, 0);
        step();
        chk("ab_regrant", {r_mem_valid, r_mem_addr}, {1'b1, 16'h0040});
        mem_ready = 1'b1;
        mem_rdata = 16'h7777;
        step();
        chk("ab_fresh_ready", r_m0_ready, 1);
        chk("ab_fresh_rdata", r_m0_rdata, 16'h7777);
        m0_req = 1'b0;
        step();

        // spurious mem_ready while IDLE
        mem_rdata = 16'h9999;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sp_idle", {r_mem_valid, r_m0_ready, r_m1_ready}, 0);
        end
        chk("sp_rdata", r_m0_rdata, 16'h7777);
        mem_ready = 1'b0;
        step();

        m0_req = 1'b1;
        m0_addr = 16'h0060;
        step();
`ifdef ARB_TIMEOUT_EN
        chk("to_err_early", r_error, 0);
        step();
        step();
        step();
        chk("to_busy4", {r_mem_valid, r_error}, 2'b10);
        step();
        chk("to_error", r_error, 1);
        chk("to_ready", r_m0_ready, 1);
        chk("to_rdata", r_m0_rdata, 16'hFFFF);
        chk("to_valid", r_mem_valid, 0);
        m0_req = 1'b0;
        step();
        step();
        chk("to_sticky", {r_error, r_m0_ready}, 2'b10);
        reset_dut();
        chk("to_clear", r_error, 0);
`else
        for (int i = 0; i < 300; i++) begin
            chk("nt_valid", r_mem_valid, 1);
            step();
        end
        chk("nt_error", r_error, 0);
        chk("nt_no_ready", r_m0_ready, 0);
        mem_ready = 1'b1;
        mem_rdata = 16'h1111;
        step();
        chk("nt_ready", {r_m0_ready, r_m0_rdata}, {1'b1, 16'h1111});
        m0_req = 1'b0;
        mem_ready = 1'b0;
        step();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-master arbiter for the single 16-bit memory port used by the stack CPU.
- Master 0 is the CPU core; master 1 is the program loader/debug DMA.
- Registers the winning request onto the memory bus, waits for mem_ready, and returns read data and a one-cycle completion strobe to the winner.
- Sits between the CPU/loader and the memory controller.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
RR_EN_MODE, 1, 0 = fixed priority (m0 always wins), 1 = round-robin between m0/m1
TIMEOUT, 255, max BUSY cycles before abort (used only with the optional feature)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
m0_req  in  1  master 0 access request, held until m0_ready
m0_w  in  1  master 0 write (1) / read (0)
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_ready  out  1  master 0 completion strobe, 1 cycle
m0_rdata  out  DATA_W  master 0 read data, valid with m0_ready
m1_req, m1_w, m1_addr, m1_wdata, m1_ready, m1_rdata  as master 0, for master 1
mem_valid  out  1  bus request to memory
mem_w  out  1  bus write enable
mem_addr  out  ADDR_W  bus address
mem_wdata  out  DATA_W  bus write data
mem_ready  in  1  memory completion; rdata valid same cycle
mem_rdata  in  DATA_W  memory read data
owner  out  1  master granted in current/last transaction
error  out  1  sticky timeout flag (0 when feature compiled out)

Behaviour:
- Reset values: state IDLE; outputs 0 (mem_valid, mem_w, mem_addr, mem_wdata, m*_ready, m*_rdata, owner, error); last_grant=1, so m0 wins the first tie.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant it.
  - Both req: RR_EN_MODE=0 grants m0; RR_EN_MODE=1 grants !last_grant.
  - On grant: latch w/addr/wdata into the mem_* registers, set owner and last_grant, go BUSY.
- BUSY:
  - mem_valid=1; mem_* stable.
  - mem_ready=1: capture mem_rdata into the owner's m*_rdata (on reads; unchanged on writes), clear mem_valid, go DONE.
  - mem_ready=0: stay in BUSY.
  - mem_ready while not BUSY is ignored.
- DONE: owner's m*_ready=1 for exactly this cycle; all req inputs ignored; go IDLE.
- Latency: req sampled in cycle N → mem_valid in N+1. mem_ready in cycle K≥N+1 → m*_ready in K+1. Minimum is 3 cycles from req to ready.
- Back-to-back: a master may hold req through DONE; it is re-arbitrated in the following IDLE cycle. Under RR the other master wins if it is requesting.
- Master changes to addr/wdata/w while BUSY have no effect (values were latched at grant).
- Non-owner m*_ready stays 0; m*_rdata holds its last value.
- rst mid-transaction: FSM returns to IDLE and mem_valid drops next edge; transaction is abandoned with no ready strobe; error clears.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined: 8-bit counter clears on entry to BUSY and increments each BUSY cycle without mem_ready. When the count reaches TIMEOUT:
  - error is set (sticky until rst);
  - mem_valid drops;
  - the FSM goes DONE with owner m*_rdata=16'hFFFF and a ready strobe, so the requester does not hang.
- Undefined: no counter; BUSY waits indefinitely; error tied 0.

Decomposition:
- Package mem_arb_pkg: FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), ADDR_W/DATA_W defaults, TIMEOUT_RDATA=16'hFFFF.
- One sub-module: arb_pick (combinational; inputs m0_req, m1_req, last_grant, mode; outputs grant_valid, grant_id), instantiated in mem_arbiter.

Test Plan:
- Single read: m0 reads addr 16'h0020, mem_ready in 2nd BUSY cycle with rdata 16'h1234 → m0_ready one cycle, m0_rdata=16'h1234, m1_ready=0, total 4 cycles.
- Simultaneous requests, RR_EN_MODE=1, both held for 4 transactions → grant order m0,m1,m0,m1. With RR_EN_MODE=0 → m0,m0,m0,m0.
- m1 write of 16'hBEEF to 16'hFFFE; m1 changes addr to 16'h0000 while BUSY → mem_addr stays 16'hFFFE, mem_w=1 until mem_ready.
- rst asserted in the 2nd BUSY cycle → next cycle mem_valid=0, state IDLE, no ready strobe; a fresh m0 req then completes normally.
- ARB_TIMEOUT_EN with TIMEOUT=4, mem_ready never asserted → after 4 BUSY cycles error=1, m0_ready pulses with m0_rdata=16'hFFFF; error stays 1 until rst. Without the macro, mem_valid stays 1 for 300 cycles and error=0.
- Spurious mem_ready in IDLE → no state change, no ready strobes.
